// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcodes, functs, FSM states and datapath select codes.
// Both the single-cycle decoder and the multi-cycle sequencer import this package.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_RSVD,
    CL_ALU_R,
    CL_ALU_I,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_ERET
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_ERET  = 6'h18;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [2:0] PCSEL_PC4  = 3'd0;
  localparam logic [2:0] PCSEL_BR   = 3'd1;
  localparam logic [2:0] PCSEL_JUMP = 3'd2;
  localparam logic [2:0] PCSEL_VEC  = 3'd3;
  localparam logic [2:0] PCSEL_EPC  = 3'd4;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_DM  = 2'd1;
  localparam logic [1:0] WBSEL_PC  = 2'd2;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  function automatic logic is_mem(input cls_t c);
    return (c == CL_LW) || (c == CL_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction/data memory handshake bundle between the sequencer (master) and the memories (slave).
interface mc_ctrl_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational op/funct decoder: instruction class, ALU control and reserved-instruction flag.
module mc_ctrl_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [3:0] alu_op,
  output logic [1:0] ext_op,
  output logic       alu_src,
  output logic       rsvd
);

  always_comb begin
    cls     = CL_RSVD;
    alu_op  = ALU_ADD;
    ext_op  = EXT_ZERO;
    alu_src = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          cls = CL_ALU_R;
        end else if (funct == FN_SUBU) begin
          cls    = CL_ALU_R;
          alu_op = ALU_SUB;
        end
      end
      OP_ORI: begin
        cls     = CL_ALU_I;
        alu_op  = ALU_OR;
        alu_src = 1'b1;
      end
      OP_LUI: begin
        cls     = CL_ALU_I;
        alu_op  = ALU_LUI;
        ext_op  = EXT_UPPER;
        alu_src = 1'b1;
      end
      OP_LW: begin
        cls     = CL_LW;
        ext_op  = EXT_SIGN;
        alu_src = 1'b1;
      end
      OP_SW: begin
        cls     = CL_SW;
        ext_op  = EXT_SIGN;
        alu_src = 1'b1;
      end
      OP_BEQ: begin
        cls    = CL_BEQ;
        alu_op = ALU_SUB;
        ext_op = EXT_SIGN;
      end
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      OP_COP0: if (funct == FN_ERET) cls = CL_ERET;
      default: cls = CL_RSVD;
    endcase
  end

  assign rsvd = (cls == CL_RSVD);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB/EXC with memory-handshake timeouts,
// precise exceptions for reserved instructions and level IRQ, and the CP0 exception-level bit.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int IM_WAIT_MAX = 16,
  parameter int DM_WAIT_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master mem,
  input  logic [31:0]   instr,
  input  logic          alu_zero,
  input  logic          irq,
  output logic          ir_w,
  output logic          pc_w,
  output logic [2:0]    pc_sel,
  output logic          reg_w,
  output logic [1:0]    reg_dst,
  output logic [1:0]    wb_sel,
  output logic          alu_src,
  output logic [3:0]    alu_op,
  output logic [1:0]    ext_op,
  output logic          epc_w,
  output logic          epc_sel,
  output logic          exl,
  output logic          bus_err,
  output logic [2:0]    state
);

  localparam logic [15:0] IM_LIM = 16'(IM_WAIT_MAX - 1);
  localparam logic [15:0] DM_LIM = 16'(DM_WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        exl_q, exl_d;
  logic        epc_sel_q, epc_sel_d;

  cls_t        cls;
  logic [3:0]  dec_alu_op;
  logic [1:0]  dec_ext_op;
  logic        dec_alu_src;
  logic        rsvd;
  logic        im_to, dm_to;
  logic        imem_req, dmem_req, dmem_we;
  logic        unused_instr;

  assign unused_instr = ^instr[25:6];

  mc_ctrl_dec u_dec (
    .op      (instr[31:26]),
    .funct   (instr[5:0]),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .ext_op  (dec_ext_op),
    .alu_src (dec_alu_src),
    .rsvd    (rsvd)
  );

  // A limit of 0 disables the timeout; an ack in the limit cycle is still honoured.
  assign im_to = (IM_WAIT_MAX != 0) && (wait_q == IM_LIM);
  assign dm_to = (DM_WAIT_MAX != 0) && (wait_q == DM_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      exl_q     <= 1'b0;
      epc_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      exl_q     <= exl_d;
      epc_sel_q <= epc_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exl_d     = exl_q;
    epc_sel_d = epc_sel_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_w      = 1'b0;
    pc_w      = 1'b0;
    pc_sel    = PCSEL_PC4;
    reg_w     = 1'b0;
    reg_dst   = REGDST_RT;
    wb_sel    = WBSEL_ALU;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    ext_op    = EXT_ZERO;
    epc_w     = 1'b0;
    epc_sel   = 1'b0;
    bus_err   = 1'b0;

    if (!reset) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        alu_src = dec_alu_src;
        alu_op  = dec_alu_op;
        ext_op  = dec_ext_op;
      end

      unique case (state_q)
        S_FETCH: begin
          // IRQ is only taken between instructions, so the abort is always precise.
          if (irq && !exl_q) begin
            state_d   = S_EXC;
            epc_sel_d = 1'b0;
          end else begin
            imem_req = 1'b1;
            if (mem.imem_ack) begin
              ir_w    = 1'b1;
              pc_w    = 1'b1;
              state_d = S_DECODE;
            end else if (im_to) begin
              bus_err   = 1'b1;
              state_d   = S_EXC;
              epc_sel_d = 1'b0;
            end
          end
        end
        S_DECODE: begin
          if (rsvd) begin
            state_d   = S_EXC;
            epc_sel_d = 1'b1;
          end else begin
            unique case (cls)
              CL_J: begin
                pc_w    = 1'b1;
                pc_sel  = PCSEL_JUMP;
                state_d = S_FETCH;
              end
              CL_JAL: begin
                pc_w    = 1'b1;
                pc_sel  = PCSEL_JUMP;
                reg_w   = 1'b1;
                reg_dst = REGDST_RA;
                wb_sel  = WBSEL_PC;
                state_d = S_FETCH;
              end
              CL_ERET: begin
                pc_w    = 1'b1;
                pc_sel  = PCSEL_EPC;
                exl_d   = 1'b0;
                state_d = S_FETCH;
              end
              default: state_d = S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          if (cls == CL_BEQ) begin
            pc_w    = alu_zero;
            pc_sel  = PCSEL_BR;
            state_d = S_FETCH;
          end else if (is_mem(cls)) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == CL_SW);
          if (mem.dmem_ack) begin
            state_d = (cls == CL_SW) ? S_FETCH : S_WB;
          end else if (dm_to) begin
            bus_err   = 1'b1;
            state_d   = S_EXC;
            epc_sel_d = 1'b0;
          end
        end
        S_WB: begin
          reg_w   = 1'b1;
          reg_dst = (cls == CL_ALU_R) ? REGDST_RD : REGDST_RT;
          wb_sel  = (cls == CL_LW) ? WBSEL_DM : WBSEL_ALU;
          state_d = S_FETCH;
        end
        S_EXC: begin
          epc_w   = 1'b1;
          epc_sel = epc_sel_q;
          pc_w    = 1'b1;
          pc_sel  = PCSEL_VEC;
          exl_d   = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign wait_d = (state_d != state_q) ? '0 : wait_q + 16'd1;

  assign mem.imem_req = imem_req;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;
  assign exl          = exl_q;
  assign state        = state_q;

endmodule
